// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type fetch/decode controller and its ALU:
// controller state encoding, opcode/funct7 constants, ALU operation codes.
package rtype_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_READ  = 3'd3,
        ST_EXEC  = 3'd4,
        ST_WB    = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // ALU operation codes are {funct7[5], funct3}.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_op;
        logic       legal;
    } decode_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc_cur);
        return pc_cur + 32'd4;
    endfunction

endpackage

// File: rtl/rtype_decode.sv
// Field extraction and legality check for an R-type instruction word.
module rtype_decode
    import rtype_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [3:0]  o_alu_op,
    output logic        o_legal
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;

    assign w_opcode = i_ir[6:0];
    assign w_funct7 = i_ir[31:25];

    assign o_rs1    = i_ir[19:15];
    assign o_rs2    = i_ir[24:20];
    assign o_rd     = i_ir[11:7];
    assign o_alu_op = {i_ir[30], i_ir[14:12]};

    assign o_legal  = (w_opcode == OPC_RTYPE) &&
                      ((w_funct7 == FUNCT7_BASE) || (w_funct7 == FUNCT7_ALT));

endmodule

// File: rtl/rtype_fetch_ctrl.sv
// Multi-cycle fetch/decode/write-back sequencer for R-type instructions.
// Optional single-step mode: define RTYPE_FETCH_CTRL_STEP_EN.
module rtype_fetch_ctrl
    import rtype_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
`ifdef RTYPE_FETCH_CTRL_STEP_EN
    input  logic        step,
`endif
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [4:0]  R_Addr_A,
    output logic [4:0]  R_Addr_B,
    output logic [4:0]  W_Addr,
    output logic [3:0]  ALU_OP,
    output logic        Reg_Write,
    output logic        rr_en,
    output logic        f_en,
    output logic        wb_en,
    output logic [31:0] pc,
    output logic        busy,
    output logic        illegal
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic        r_illegal;
    decode_t     w_dec;
    logic        w_start;
    logic        w_continue;

    rtype_decode u_decode (
        .i_ir     (r_ir),
        .o_rs1    (w_dec.rs1),
        .o_rs2    (w_dec.rs2),
        .o_rd     (w_dec.rd),
        .o_alu_op (w_dec.alu_op),
        .o_legal  (w_dec.legal)
    );

`ifdef RTYPE_FETCH_CTRL_STEP_EN
    assign w_start    = step;
    assign w_continue = 1'b0;
`else
    assign w_start    = run;
    assign w_continue = run;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_FETCH;
            ST_FETCH: w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_READ;
            ST_READ:  w_next = ST_EXEC;
            ST_EXEC:  w_next = ST_WB;
            ST_WB: begin
                if (!w_dec.legal) begin
                    w_next = ST_HALT;
                end else if (w_continue) begin
                    w_next = ST_FETCH;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_HALT:  w_next = ST_HALT;
            default:  w_next = ST_IDLE;
        endcase
    end

    // IR holds from the end of LOAD until the next LOAD, so decoded fields
    // stay stable from READ through WB. The illegal flag rises entering WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == ST_LOAD) begin
                r_ir <= imem_data;
            end
            if ((r_state == ST_EXEC) && !w_dec.legal) begin
                r_illegal <= 1'b1;
            end
            if ((r_state == ST_WB) && w_dec.legal) begin
                r_pc <= pc_next(r_pc);
            end
        end
    end

    always_comb begin
        rr_en     = 1'b0;
        f_en      = 1'b0;
        wb_en     = 1'b0;
        Reg_Write = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            ST_READ: rr_en = 1'b1;
            ST_EXEC: f_en  = 1'b1;
            ST_WB: begin
                wb_en     = 1'b1;
                Reg_Write = w_dec.legal && (w_dec.rd != 5'd0);
            end
            ST_IDLE, ST_HALT: busy = 1'b0;
            default: ;
        endcase
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign illegal   = r_illegal;
    assign R_Addr_A  = w_dec.rs1;
    assign R_Addr_B  = w_dec.rs2;
    assign W_Addr    = w_dec.rd;
    assign ALU_OP    = w_dec.alu_op;

endmodule

// File: tb/tb_rtype_fetch_ctrl.sv
// Bench for rtype_fetch_ctrl: directed cases plus random R-type streams
// checked against an instruction-level reference model.
module tb_rtype_fetch_ctrl;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam logic [31:0] WPC   = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, step;
    logic [31:0] imem_data, imem_addr, pc;
    logic [4:0]  ra, rb, wa;
    logic [3:0]  aop;
    logic        rw, rr_en, f_en, wb_en, busy, illegal;

    logic        rst_w, run_w, step_w;
    logic [31:0] data_w, addr_w, pc_w;
    logic [4:0]  ra_w, rb_w, wa_w;
    logic [3:0]  aop_w;
    logic        rw_w, rr_w, f_w, wb_w, busy_w, ill_w;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc;

    rtype_fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .run(run),
`ifdef RTYPE_FETCH_CTRL_STEP_EN
        .step(step),
`endif
        .imem_addr(imem_addr), .imem_data(imem_data),
        .R_Addr_A(ra), .R_Addr_B(rb), .W_Addr(wa), .ALU_OP(aop),
        .Reg_Write(rw), .rr_en(rr_en), .f_en(f_en), .wb_en(wb_en),
        .pc(pc), .busy(busy), .illegal(illegal)
    );

    rtype_fetch_ctrl #(.RESET_PC(WPC)) dut_wrap (
        .clk(clk), .rst(rst_w), .run(run_w),
`ifdef RTYPE_FETCH_CTRL_STEP_EN
        .step(step_w),
`endif
        .imem_addr(addr_w), .imem_data(data_w),
        .R_Addr_A(ra_w), .R_Addr_B(rb_w), .W_Addr(wa_w), .ALU_OP(aop_w),
        .Reg_Write(rw_w), .rr_en(rr_w), .f_en(f_w), .wb_en(wb_w),
        .pc(pc_w), .busy(busy_w), .illegal(ill_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] ins);
        return (ins[6:0] == 7'b0110011) &&
               ((ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000));
    endfunction

    // One instruction = five observed cycles (FETCH..WB) after the edge that
    // leaves IDLE/WB. run is scrambled mid-instruction; only its WB value counts.
    task automatic do_instr(input logic [31:0] ins, input bit go_after);
        bit legal;
        legal = is_legal(ins);
        imem_data = ins;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("busy", busy, 1);
            check_eq("imem_addr", imem_addr, exp_pc);
            check_eq("pc", pc, exp_pc);
            check_eq("rr_en", rr_en, k == 2);
            check_eq("f_en", f_en, k == 3);
            check_eq("wb_en", wb_en, k == 4);
            check_eq("reg_write", rw, (k == 4) && legal && (ins[11:7] != 5'd0));
            if (k >= 2) begin
                check_eq("r_addr_a", ra, ins[19:15]);
                check_eq("r_addr_b", rb, ins[24:20]);
                check_eq("w_addr", wa, ins[11:7]);
                check_eq("alu_op", aop, {ins[30], ins[14:12]});
            end
            if (k == 4) check_eq("illegal", illegal, !legal);
            if (k == 1) run = 1'($urandom_range(0, 1));
        end
        if (legal) exp_pc = exp_pc + 32'd4;
        run = go_after;
        if (legal && !go_after) begin
            @(posedge clk); #1;
            check_eq("idle_busy", busy, 0);
            check_eq("idle_pc", pc, exp_pc);
            run = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_rtype();
        logic [31:0] ins;
        ins        = $urandom;
        ins[6:0]   = 7'b0110011;
        ins[31:25] = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0100000;
        if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; imem_data = 32'd0;
        rst_w = 1'b1; run_w = 1'b0; step_w = 1'b0; data_w = 32'd0;
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pc", pc, RPC);
        check_eq("rst_imem_addr", imem_addr, RPC);
        check_eq("rst_strobes", {rr_en, f_en, wb_en, rw}, 0);
        check_eq("rst_fields", {ra, rb, wa, aop}, 0);
        check_eq("rst_illegal", illegal, 0);
        @(negedge clk); rst = 1'b0;
        exp_pc = RPC;
        @(negedge clk);
        check_eq("idle_no_run", busy, 0);

`ifdef RTYPE_FETCH_CTRL_STEP_EN
        begin
            int pulses;
            pulses = 0;
            run = 1'b1;
            @(negedge clk); check_eq("step_run_ignored", busy, 0);
            step = 1'b1; @(negedge clk); step = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (wb_en) pulses++;
            end
            check_eq("step_wb_pulses", pulses, 1);
            check_eq("step_back_idle", busy, 0);
            check_eq("step_pc", pc, RPC + 32'd4);
        end
`else
        run = 1'b1;
        do_instr(32'h002081B3, 1'b1);
        do_instr(32'h407302B3, 1'b1);
        do_instr(32'h00208033, 1'b0);
        check_eq("pc_after_three", exp_pc, RPC + 32'd12);
        for (int i = 0; i < 40; i++) begin
            do_instr(rand_rtype(), $urandom_range(0, 3) != 0);
        end

        // Reset while in EXEC aborts the instruction.
        imem_data = 32'h002081B3;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        check_eq("exec_f_en", f_en, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_pc", pc, RPC);
        check_eq("abort_strobes", {rr_en, f_en, wb_en, rw}, 0);
        check_eq("abort_fields", {ra, rb, wa, aop}, 0);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("abort_no_wb", {wb_en, rw}, 0);
        end
        @(negedge clk); rst = 1'b0;
        exp_pc = RPC;
        @(negedge clk);
        check_eq("abort_idle", busy, 0);
        check_eq("abort_pc_hold", pc, RPC);

        // Legal instruction, then an illegal one that halts the sequencer.
        run = 1'b1;
        do_instr(rand_rtype(), 1'b1);
        do_instr(32'h00000013, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("halt_busy", busy, 0);
            check_eq("halt_illegal", illegal, 1);
            check_eq("halt_pc", pc, exp_pc);
            check_eq("halt_wb", {wb_en, rw}, 0);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; run = 1'b0;
        check_eq("halt_cleared", illegal, 0);
        check_eq("halt_reset_pc", pc, RPC);

        // PC wrap from 0xFFFF_FFFC.
        @(negedge clk); rst_w = 1'b0; run_w = 1'b1; data_w = 32'h002081B3;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        check_eq("wrap_wb", wb_w, 1);
        check_eq("wrap_pc_before", pc_w, WPC);
        run_w = 1'b0;
        @(posedge clk); #1;
        check_eq("wrap_pc_after", pc_w, 32'd0);
        check_eq("wrap_addr_after", addr_w, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
